bus_control_unit: RTL and testbench

BUS_CONTROL_UNIT -- requirements
Module: bus_control_unit

---
 rtl/mano_pkg.sv | 45 ++++
 rtl/bus_control_unit_seq_counter.sv | 24 ++
 rtl/bus_control_unit.sv | 269 ++++++++++++++++++++++++++
 tb/tb_bus_control_unit.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mano_pkg.sv
// Shared encodings for the Mano basic-computer control unit:
// bus sources, ALU selects, opcode values and register-ref bit positions.
package mano_pkg;

   typedef enum logic [2:0] {
      BUS_NONE = 3'd0,
      BUS_AR   = 3'd1,
      BUS_PC   = 3'd2,
      BUS_DR   = 3'd3,
      BUS_AC   = 3'd4,
      BUS_IR   = 3'd5,
      BUS_TR   = 3'd6,
      BUS_MEM  = 3'd7
   } bus_sel_e;

   typedef enum logic [2:0] {
      ALU_AND  = 3'd0,
      ALU_ADD  = 3'd1,
      ALU_PASS = 3'd2,
      ALU_CMA  = 3'd3
   } alu_op_e;

   localparam logic [2:0] OP_AND = 3'd0;
   localparam logic [2:0] OP_ADD = 3'd1;
   localparam logic [2:0] OP_LDA = 3'd2;
   localparam logic [2:0] OP_STA = 3'd3;
   localparam logic [2:0] OP_BUN = 3'd4;
   localparam logic [2:0] OP_BSA = 3'd5;
   localparam logic [2:0] OP_ISZ = 3'd6;
   localparam logic [2:0] OP_REG = 3'd7;

   localparam int RR_CLA = 11;
   localparam int RR_CMA = 9;
   localparam int RR_INC = 5;
   localparam int RR_SPA = 4;
   localparam int RR_SNA = 3;
   localparam int RR_SZA = 2;
   localparam int RR_HLT = 0;

   localparam logic [15:0] IO_ION = 16'hF080;
   localparam logic [15:0] IO_IOF = 16'hF040;

   localparam logic [3:0] SC_T3 = 4'd3;

endpackage

// File: rtl/bus_control_unit_seq_counter.sv
// 4-bit sequence counter: sync active-low reset, clr over inc.
// Ports: clk, rst_n, clr, inc in; cnt out.
module seq_counter (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       clr,
   input  logic       inc,
   output logic [3:0] cnt
);

   logic [3:0] r_cnt;

   always_ff @(posedge clk) begin
      if (!rst_n)
         r_cnt <= 4'd0;
      else if (clr)
         r_cnt <= 4'd0;
      else if (inc)
         r_cnt <= r_cnt + 4'd1;
   end

   assign cnt = r_cnt;

endmodule

// File: rtl/bus_control_unit.sv
// Hardwired control for the Mano basic computer: decodes sc, I, D, IR
// and status into bus/register/memory strobes. Ports: clk, rst_n, ir,
// dr_zero, ac_zero, ac_sign, irq in; bus_sel, register controls,
// alu_op, mem_rd/mem_wr, sc, halted, ien out. Macro INTERRUPT_EN adds
// ION/IOF, the R flip-flop and the interrupt cycle.
module bus_control_unit
   import mano_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] ir,
   input  logic        dr_zero,
   input  logic        ac_zero,
   input  logic        ac_sign,
   input  logic        irq,
   output logic [2:0]  bus_sel,
   output logic        ar_ld,
   output logic        ar_inc,
   output logic        ar_clr,
   output logic        pc_ld,
   output logic        pc_inc,
   output logic        pc_clr,
   output logic        dr_ld,
   output logic        dr_inc,
   output logic        ac_ld,
   output logic        ac_inc,
   output logic        ac_clr,
   output logic        ir_ld,
   output logic        tr_ld,
   output logic [2:0]  alu_op,
   output logic        mem_rd,
   output logic        mem_wr,
   output logic [3:0]  sc,
   output logic        halted,
   output logic        ien
);

   logic       r_i;
   logic [2:0] r_d;
   logic       r_halted;
   bus_sel_e   w_bus;
   alu_op_e    w_alu;
   logic       w_sc_inc;
   logic       w_sc_clr;
   logic       w_latch;
   logic       w_set_halt;
   logic       w_unused;
`ifdef INTERRUPT_EN
   logic       r_ien;
   logic       r_r;
   logic       w_ien_set;
   logic       w_ien_clr;
   logic       w_r_clr;
`endif

   seq_counter u_sc (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (w_sc_clr),
      .inc   (w_sc_inc),
      .cnt   (sc)
   );

   always_comb begin
      w_bus      = BUS_NONE;
      w_alu      = ALU_AND;
      ar_ld      = 1'b0;
      ar_inc     = 1'b0;
      ar_clr     = 1'b0;
      pc_ld      = 1'b0;
      pc_inc     = 1'b0;
      pc_clr     = 1'b0;
      dr_ld      = 1'b0;
      dr_inc     = 1'b0;
      ac_ld      = 1'b0;
      ac_inc     = 1'b0;
      ac_clr     = 1'b0;
      ir_ld      = 1'b0;
      tr_ld      = 1'b0;
      mem_rd     = 1'b0;
      mem_wr     = 1'b0;
      w_sc_inc   = 1'b0;
      w_sc_clr   = 1'b0;
      w_latch    = 1'b0;
      w_set_halt = 1'b0;
`ifdef INTERRUPT_EN
      w_ien_set  = 1'b0;
      w_ien_clr  = 1'b0;
      w_r_clr    = 1'b0;
`endif
      if (!rst_n) begin
         w_sc_clr = 1'b1;
      end else if (r_halted) begin
         w_sc_clr = 1'b1;
      end
`ifdef INTERRUPT_EN
      else if (r_r && (sc < SC_T3)) begin
         // Interrupt cycle replaces fetch while R is pending.
         w_sc_inc = 1'b1;
         case (sc)
            4'd0: begin
               ar_clr = 1'b1;
               w_bus  = BUS_PC;
               tr_ld  = 1'b1;
            end
            4'd1: begin
               w_bus  = BUS_TR;
               mem_wr = 1'b1;
               pc_clr = 1'b1;
            end
            default: begin
               pc_inc    = 1'b1;
               w_ien_clr = 1'b1;
               w_r_clr   = 1'b1;
               w_sc_clr  = 1'b1;
            end
         endcase
      end
`endif
      else begin
         w_sc_inc = 1'b1;
         case (sc)
            4'd0: begin
               w_bus = BUS_PC;
               ar_ld = 1'b1;
            end
            4'd1: begin
               w_bus  = BUS_MEM;
               mem_rd = 1'b1;
               ir_ld  = 1'b1;
               pc_inc = 1'b1;
            end
            4'd2: begin
               w_bus   = BUS_IR;
               ar_ld   = 1'b1;
               w_latch = 1'b1;
            end
            4'd3: begin
               if (r_d != OP_REG) begin
                  if (r_i) begin
                     w_bus  = BUS_MEM;
                     mem_rd = 1'b1;
                     ar_ld  = 1'b1;
                  end
               end else if (!r_i) begin
                  w_sc_clr = 1'b1;
                  if (ir[RR_CLA]) begin
                     ac_clr = 1'b1;
                  end else if (ir[RR_CMA]) begin
                     ac_ld = 1'b1;
                     w_alu = ALU_CMA;
                  end else if (ir[RR_INC]) begin
                     ac_inc = 1'b1;
                  end
                  pc_inc = (ir[RR_SPA] && !ac_sign)
                         | (ir[RR_SNA] && ac_sign)
                         | (ir[RR_SZA] && ac_zero);
                  w_set_halt = ir[RR_HLT];
               end else begin
                  w_sc_clr = 1'b1;
`ifdef INTERRUPT_EN
                  w_ien_set = (ir == IO_ION);
                  w_ien_clr = (ir == IO_IOF);
`endif
               end
            end
            4'd4: begin
               case (r_d)
                  OP_AND, OP_ADD, OP_LDA, OP_ISZ: begin
                     w_bus  = BUS_MEM;
                     mem_rd = 1'b1;
                     dr_ld  = 1'b1;
                  end
                  OP_STA: begin
                     w_bus    = BUS_AC;
                     mem_wr   = 1'b1;
                     w_sc_clr = 1'b1;
                  end
                  OP_BUN: begin
                     w_bus    = BUS_AR;
                     pc_ld    = 1'b1;
                     w_sc_clr = 1'b1;
                  end
                  OP_BSA: begin
                     w_bus  = BUS_PC;
                     mem_wr = 1'b1;
                     ar_inc = 1'b1;
                  end
                  default: w_sc_clr = 1'b1;
               endcase
            end
            4'd5: begin
               case (r_d)
                  OP_AND, OP_ADD, OP_LDA: begin
                     ac_ld    = 1'b1;
                     w_sc_clr = 1'b1;
                     case (r_d)
                        OP_AND:  w_alu = ALU_AND;
                        OP_ADD:  w_alu = ALU_ADD;
                        default: w_alu = ALU_PASS;
                     endcase
                  end
                  OP_BSA: begin
                     w_bus    = BUS_AR;
                     pc_ld    = 1'b1;
                     w_sc_clr = 1'b1;
                  end
                  OP_ISZ:  dr_inc   = 1'b1;
                  default: w_sc_clr = 1'b1;
               endcase
            end
            4'd6: begin
               w_sc_clr = 1'b1;
               if (r_d == OP_ISZ) begin
                  w_bus  = BUS_DR;
                  mem_wr = 1'b1;
                  pc_inc = dr_zero;
               end
            end
            default: w_sc_clr = 1'b1;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_i      <= 1'b0;
         r_d      <= 3'd0;
         r_halted <= 1'b0;
      end else begin
         if (w_latch) begin
            r_i <= ir[15];
            r_d <= ir[14:12];
         end
         if (w_set_halt)
            r_halted <= 1'b1;
      end
   end

`ifdef INTERRUPT_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_ien <= 1'b0;
         r_r   <= 1'b0;
      end else begin
         if (w_ien_clr)
            r_ien <= 1'b0;
         else if (w_ien_set)
            r_ien <= 1'b1;
         if (w_r_clr)
            r_r <= 1'b0;
         else if ((sc >= SC_T3) && r_ien && irq)
            r_r <= 1'b1;
      end
   end

   assign ien = r_ien;
`else
   assign ien = 1'b0;
`endif

   // NOP register-ref bits; irq only matters with interrupts built in.
   assign w_unused = ^{irq, ir[10], ir[8:6], ir[1]};

   assign bus_sel = w_bus;
   assign alu_op  = w_alu;
   assign halted  = r_halted;

endmodule

// File: tb/tb_bus_control_unit.sv
// Bench for bus_control_unit: instruction-level model builds the
// expected control listing per step; one process compares each cycle.
module tb_bus_control_unit;

   typedef struct packed {
      logic [2:0] bus;
      logic ar_ld, ar_inc, ar_clr;
      logic pc_ld, pc_inc, pc_clr;
      logic dr_ld, dr_inc;
      logic ac_ld, ac_inc, ac_clr;
      logic ir_ld, tr_ld;
      logic [2:0] alu;
      logic mem_rd, mem_wr;
   } ctl_t;

   typedef struct packed {
      ctl_t       c;
      logic [3:0] sc;
      logic       halted;
      logic       ien;
      logic       chk_st;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic [15:0] ir;
   logic        dr_zero, ac_zero, ac_sign, irq;
   logic [2:0]  bus_sel, alu_op;
   logic        ar_ld, ar_inc, ar_clr, pc_ld, pc_inc, pc_clr;
   logic        dr_ld, dr_inc, ac_ld, ac_inc, ac_clr, ir_ld, tr_ld;
   logic        mem_rd, mem_wr, halted, ien;
   logic [3:0]  sc;

   int   checks = 0;
   int   errors = 0;
   exp_t exp_q[$];
   int   pins[int];
   int   k;
   int   abort_at;
   bit   aborted;
   bit   m_halted, m_ien, m_r;
   ctl_t act;

   bus_control_unit dut (
      .clk(clk), .rst_n(rst_n), .ir(ir),
      .dr_zero(dr_zero), .ac_zero(ac_zero), .ac_sign(ac_sign),
      .irq(irq), .bus_sel(bus_sel),
      .ar_ld(ar_ld), .ar_inc(ar_inc), .ar_clr(ar_clr),
      .pc_ld(pc_ld), .pc_inc(pc_inc), .pc_clr(pc_clr),
      .dr_ld(dr_ld), .dr_inc(dr_inc), .ac_ld(ac_ld),
      .ac_inc(ac_inc), .ac_clr(ac_clr), .ir_ld(ir_ld),
      .tr_ld(tr_ld), .alu_op(alu_op), .mem_rd(mem_rd),
      .mem_wr(mem_wr), .sc(sc), .halted(halted), .ien(ien)
   );

   assign act = {bus_sel, ar_ld, ar_inc, ar_clr, pc_ld, pc_inc,
                 pc_clr, dr_ld, dr_inc, ac_ld, ac_inc, ac_clr,
                 ir_ld, tr_ld, alu_op, mem_rd, mem_wr};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         checks++;
         if (act !== e.c) begin
            errors++;
            $display("FAIL ctl t=%0t got %h want %h",
                     $time, act, e.c);
         end
         if (e.chk_st) begin
            checks++;
            if ({sc, halted, ien} !== {e.sc, e.halted, e.ien}) begin
               errors++;
               $display("FAIL state t=%0t got sc=%0d h=%0b ien=%0b want sc=%0d h=%0b ien=%0b",
                        $time, sc, halted, ien, e.sc, e.halted, e.ien);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   task automatic next_cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input ctl_t c, input int t, input bit h,
                       input bit ie, input bit chk);
      exp_t e;
      e.c      = c;
      e.sc     = t[3:0];
      e.halted = h;
      e.ien    = ie;
      e.chk_st = chk;
      exp_q.push_back(e);
   endtask

   task automatic lit(input string nm, input int got, input int want);
      checks++;
      if (got != want) begin
         errors++;
         $display("FAIL %s got %0d want %0d", nm, got, want);
      end
   endtask

   task automatic step(input ctl_t c, input int t);
      if (aborted) return;
      if (k == abort_at) begin
         rst_n = 1'b0;
         push('0, t, m_halted, m_ien, 1'b1);
         next_cyc();
         m_halted = 0;
         m_ien    = 0;
         m_r      = 0;
         push('0, 0, 1'b0, 1'b0, 1'b1);
         next_cyc();
         rst_n   = 1'b1;
         aborted = 1;
         return;
      end
      push(c, t, m_halted, m_ien, 1'b1);
      #1;
      if (pins.exists(k))
         lit($sformatf("pin bus k=%0d", k), int'(bus_sel), pins[k]);
      @(posedge clk);
      #1;
      if (t >= 3 && m_ien && irq)
         m_r = 1;
      k++;
   endtask

   task automatic do_reset(input int n, input bit known);
      ctl_t z;
      z = '0;
      rst_n = 1'b0;
      push(z, 0, 1'b0, 1'b0, 1'b0);
      next_cyc();
      m_halted = 0;
      m_ien    = 0;
      m_r      = 0;
      for (int j = 1; j < n; j++) begin
         push(z, 0, 1'b0, 1'b0, known);
         next_cyc();
      end
      rst_n = 1'b1;
   endtask

   task automatic run_instr(input logic [15:0] w, input logic dz,
                            input logic az, input logic as_,
                            input logic irqv, input int abt);
      ctl_t       c;
      logic       i;
      logic [2:0] d;
      k        = 0;
      abort_at = abt;
      aborted  = 0;
      dr_zero  = dz;
      ac_zero  = az;
      ac_sign  = as_;
      irq      = irqv;
`ifdef INTERRUPT_EN
      if (m_r) begin
         c = '0; c.ar_clr = 1; c.bus = 3'd2; c.tr_ld = 1;
         step(c, 0);
         c = '0; c.bus = 3'd6; c.mem_wr = 1; c.pc_clr = 1;
         step(c, 1);
         c = '0; c.pc_inc = 1;
         step(c, 2);
         m_ien = 0;
         m_r   = 0;
      end
`endif
      ir = 16'($urandom);
      c = '0; c.bus = 3'd2; c.ar_ld = 1;
      step(c, 0);
      c = '0; c.bus = 3'd7; c.mem_rd = 1;
      c.ir_ld = 1; c.pc_inc = 1;
      step(c, 1);
      ir = w;
      c = '0; c.bus = 3'd5; c.ar_ld = 1;
      step(c, 2);
      i = w[15];
      d = w[14:12];
      if (d != 3'd7) begin
         c = '0;
         if (i) begin
            c.bus = 3'd7; c.mem_rd = 1; c.ar_ld = 1;
         end
         step(c, 3);
         if (d <= 3'd2 || d == 3'd6) begin
            c = '0; c.bus = 3'd7; c.mem_rd = 1; c.dr_ld = 1;
            step(c, 4);
            c = '0;
            if (d == 3'd6) c.dr_inc = 1;
            else begin
               c.ac_ld = 1;
               c.alu   = d;
            end
            step(c, 5);
            if (d == 3'd6) begin
               c = '0; c.bus = 3'd3; c.mem_wr = 1; c.pc_inc = dz;
               step(c, 6);
            end
         end else if (d == 3'd3) begin
            c = '0; c.bus = 3'd4; c.mem_wr = 1;
            step(c, 4);
         end else if (d == 3'd4) begin
            c = '0; c.bus = 3'd1; c.pc_ld = 1;
            step(c, 4);
         end else begin
            c = '0; c.bus = 3'd2; c.mem_wr = 1; c.ar_inc = 1;
            step(c, 4);
            c = '0; c.bus = 3'd1; c.pc_ld = 1;
            step(c, 5);
         end
      end else if (!i) begin
         c = '0;
         if (w[11]) c.ac_clr = 1;
         else if (w[9]) begin
            c.ac_ld = 1;
            c.alu   = 3'd3;
         end else if (w[5]) c.ac_inc = 1;
         c.pc_inc = (w[4] && !as_) || (w[3] && as_) || (w[2] && az);
         step(c, 3);
         if (w[0] && !aborted) m_halted = 1;
      end else begin
         c = '0;
         step(c, 3);
`ifdef INTERRUPT_EN
         if (!aborted) begin
            if (w == 16'hF080) m_ien = 1;
            if (w == 16'hF040) m_ien = 0;
         end
`endif
      end
      abort_at = -1;
      pins.delete();
   endtask

   initial begin
      rst_n    = 1'b0;
      ir       = 16'h0;
      dr_zero  = 0;
      ac_zero  = 0;
      ac_sign  = 0;
      irq      = 0;
      abort_at = -1;
      @(posedge clk);
      #1;
      do_reset(3, 1'b1);
      lit("reset sc", int'(sc), 0);

      pins[0] = 2; pins[1] = 7; pins[2] = 5; pins[4] = 7;
      run_instr(16'h2123, 0, 0, 0, 0, -1);
      lit("lda end sc", int'(sc), 0);

      run_instr(16'h1010, 0, 0, 0, 0, 4);
      lit("abort sc", int'(sc), 0);
      run_instr(16'h0005, 0, 0, 0, 0, -1);
      run_instr(16'h1010, 0, 0, 0, 0, -1);
      run_instr(16'hA001, 0, 0, 0, 0, -1);
      run_instr(16'h3004, 0, 0, 0, 1, -1);
      run_instr(16'hC010, 0, 0, 0, 0, -1);
      pins[4] = 2; pins[5] = 1;
      run_instr(16'h5200, 0, 0, 0, 0, -1);
      pins[3] = 7; pins[6] = 3;
      run_instr(16'hE050, 1, 0, 0, 0, -1);
      run_instr(16'h6050, 0, 0, 0, 0, -1);

      run_instr(16'h7800, 0, 0, 0, 0, -1);
      run_instr(16'h7200, 0, 0, 0, 0, -1);
      run_instr(16'h7020, 0, 0, 0, 0, -1);
      run_instr(16'h7A20, 0, 0, 0, 0, -1);
      run_instr(16'h7220, 0, 0, 0, 0, -1);
      run_instr(16'h7010, 0, 0, 0, 0, -1);
      run_instr(16'h7010, 0, 0, 1, 0, -1);
      run_instr(16'h7008, 0, 0, 0, 0, -1);
      run_instr(16'h7008, 0, 0, 1, 0, -1);
      run_instr(16'h7004, 0, 1, 0, 0, -1);
      run_instr(16'h701C, 0, 1, 1, 0, -1);
      run_instr(16'h77C2, 0, 1, 1, 0, -1);

      run_instr(16'hF080, 0, 0, 0, 0, -1);
      run_instr(16'h1010, 0, 0, 0, 1, -1);
`ifdef INTERRUPT_EN
      lit("ion ien", int'(ien), 1);
      pins[1] = 6;
      run_instr(16'h7020, 0, 0, 0, 0, -1);
      lit("isr ien", int'(ien), 0);
      run_instr(16'hF080, 0, 0, 0, 0, -1);
      run_instr(16'hF040, 0, 0, 0, 1, -1);
      run_instr(16'h2000, 0, 0, 0, 1, -1);
      lit("iof ien", int'(ien), 0);
`else
      lit("no ien", int'(ien), 0);
      run_instr(16'h7020, 0, 0, 0, 1, -1);
`endif

      run_instr(16'h7001, 0, 0, 0, 0, -1);
      lit("halted", int'(halted), 1);
      for (int j = 0; j < 10; j++) begin
         irq = j[0];
         ir  = 16'($urandom);
         step('0, 0);
      end
      do_reset(2, 1'b1);
      lit("unhalted", int'(halted), 0);
      run_instr(16'h2123, 0, 0, 0, 0, -1);

      next_cyc();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
